// File: rtl/capture_pkg.sv
// Shared definitions for the capture sequencer and its skid buffer.
package capture_pkg;

    // Channel select is three bits wide (eight store channels).
    localparam int CH_W = 3;

    // log2 of words held per channel in the production store.
    localparam int DEFAULT_DEPTH_LOG2 = 13;

    // Acquisition phases, from arming through the per-channel readout loop.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_CAPTURE,
        ST_SELECT,
        ST_SETTLE,
        ST_READ,
        ST_DRAIN
    } state_e;

endpackage

// File: rtl/seq_skid_fifo.sv
// Small synchronous FIFO that absorbs read data landing from the store.
// The producer is credit-limited, so overflow guards are only a safety net.
module seq_skid_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 20,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CNT_W-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pop_ok, push_ok;

    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;

    // Pointer, occupancy and storage updates; flush wins over any transfer.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        pop_ok   = pop && (count_q != '0);
        push_ok  = push && ((count_q != FULL_CNT) || pop_ok);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_d = (rd_ptr_q == LAST_IDX) ? '0 : rd_ptr_q + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count_d = count_q + 1'b1;
            end else if (!push_ok && pop_ok) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // Control state resets; the storage array carries no reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
        mem_q <= mem_d;
    end

endmodule

// File: rtl/capture_sequencer.sv
// Sequences one acquisition: arm, trigger, fill the store, then read every
// channel out as a tagged, backpressured stream through a credit-limited skid.
module capture_sequencer
    import capture_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2,
    parameter int NUM_CH     = 8,
    parameter int DATA_W     = 16,
    parameter int SETTLE     = 2,
    parameter int READ_LAT   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arm,
    input  logic              abort,
    input  logic              trig,
    input  logic              ffa_n,
    input  logic [DATA_W-1:0] fifo_dout,
    output logic              load,
    output logic              rden,
    output logic [CH_W-1:0]   cntrl_bits,
    output logic [DATA_W-1:0] out_data,
    output logic [CH_W-1:0]   out_ch,
    output logic              out_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = DEPTH_LOG2 + 1;
    localparam logic [CNT_W-1:0] WORDS     = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [CNT_W-1:0] WORD_LAST = WORDS - 1'b1;
    localparam int SKID_DEPTH = READ_LAT + 2;
    localparam int SKID_W     = DATA_W + CH_W + 1;
    localparam int CRED_W     = $clog2(SKID_DEPTH + 1);
    localparam logic [CRED_W-1:0] CREDIT_INIT = CRED_W'(SKID_DEPTH);
    localparam logic [CH_W-1:0]   LAST_CH     = CH_W'(NUM_CH - 1);
    localparam int SET_W = $clog2(SETTLE + 1);
    localparam logic [SET_W-1:0]  SET_LAST    = SET_W'(SETTLE - 1);

    state_e              state_q, state_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [CNT_W-1:0]    word_q, word_d;
    logic [SET_W-1:0]    settle_q, settle_d;
    logic [CH_W-1:0]     cntrl_q, cntrl_d;
    logic [CRED_W-1:0]   credit_q, credit_d;
    logic                done_q, done_d;
    logic [READ_LAT-1:0] vld_q, vld_d;
    logic [READ_LAT-1:0] last_q, last_d;

    logic [SKID_W-1:0]   skid_head;
    logic [CRED_W-1:0]   skid_count;
    logic                pop;
    logic                last_issue;

    seq_skid_fifo #(
        .DEPTH (SKID_DEPTH),
        .WIDTH (SKID_W),
        .CNT_W (CRED_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (abort),
        .push      (vld_q[READ_LAT-1]),
        .push_data ({last_q[READ_LAT-1], ch_q, fifo_dout}),
        .pop       (pop),
        .pop_data  (skid_head),
        .count     (skid_count)
    );

    assign out_valid  = (skid_count != '0);
    assign pop        = out_valid && out_ready;
    assign out_data   = skid_head[DATA_W-1:0];
    assign out_ch     = skid_head[DATA_W +: CH_W];
    assign out_last   = out_valid && skid_head[SKID_W-1];
    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;
    assign cntrl_bits = cntrl_q;

    // Next-state, strobes, read pipeline and credit accounting; abort overrides all.
    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        word_d     = word_q;
        settle_d   = settle_q;
        cntrl_d    = cntrl_q;
        credit_d   = credit_q;
        done_d     = 1'b0;
        load       = 1'b0;
        rden       = 1'b0;
        last_issue = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (arm) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (trig) state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                load = ffa_n;
                if (!ffa_n) begin
                    ch_d    = '0;
                    state_d = ST_SELECT;
                end
            end
            ST_SELECT: begin
                settle_d = '0;
                word_d   = '0;
                state_d  = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (settle_q == SET_LAST) state_d = ST_READ;
                else settle_d = settle_q + 1'b1;
            end
            ST_READ: begin
                rden = (credit_q != '0);
                if (rden) begin
                    last_issue = (ch_q == LAST_CH) && (word_q == WORD_LAST);
                    word_d     = word_q + 1'b1;
                    if (word_d == WORDS) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if ((vld_q == '0) && (skid_count == '0)) begin
                    if (ch_q == LAST_CH) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        ch_d    = ch_q + 1'b1;
                        state_d = ST_SELECT;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        vld_d  = READ_LAT'({vld_q, rden});
        last_d = READ_LAT'({last_q, last_issue});
        if (rden && !pop) credit_d = credit_q - 1'b1;
        else if (!rden && pop) credit_d = credit_q + 1'b1;

        if (abort) begin
            state_d  = ST_IDLE;
            load     = 1'b0;
            rden     = 1'b0;
            done_d   = 1'b0;
            credit_d = CREDIT_INIT;
            vld_d    = '0;
            last_d   = '0;
        end

        if (state_d == ST_SELECT) cntrl_d = ch_d;
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ch_q     <= '0;
            word_q   <= '0;
            settle_q <= '0;
            cntrl_q  <= '0;
            credit_q <= CREDIT_INIT;
            done_q   <= 1'b0;
            vld_q    <= '0;
            last_q   <= '0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            word_q   <= word_d;
            settle_q <= settle_d;
            cntrl_q  <= cntrl_d;
            credit_q <= credit_d;
            done_q   <= done_d;
            vld_q    <= vld_d;
            last_q   <= last_d;
        end
    end

endmodule

// File: tb/tb_capture_sequencer.sv
// Bench for capture_sequencer with a small store model and a stream scoreboard.
module tb_capture_sequencer;

    localparam int DEPTH_LOG2 = 4;
    localparam int WORDS      = 1 << DEPTH_LOG2;
    localparam int NUM_CH     = 8;
    localparam int DATA_W     = 16;
    localparam int SETTLE     = 2;
    localparam int READ_LAT   = 2;
    localparam int LIMIT      = 4000;

    logic              clk = 1'b0;
    logic              rst, arm, abort, trig, out_ready;
    logic              ffa_n;
    logic [DATA_W-1:0] fifo_dout;
    logic              load, rden, out_last, out_valid, busy, done;
    logic [2:0]        cntrl_bits, out_ch;
    logic [DATA_W-1:0] out_data;

    int checks = 0;
    int errors = 0;
    logic [DATA_W+3:0] exp_q[$];
    logic [DATA_W+3:0] got, want;

    int done_cnt = 0, last_cnt = 0, pop_cnt = 0, rden_cnt = 0;

    // Store model state
    logic              store_clr;
    int                load_cnt = 0;
    int                rd_addr  = 0;
    logic [2:0]        sel_q    = '0;
    logic [DATA_W-1:0] pipe [READ_LAT];

    capture_sequencer #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .NUM_CH     (NUM_CH),
        .DATA_W     (DATA_W),
        .SETTLE     (SETTLE),
        .READ_LAT   (READ_LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .arm        (arm),
        .abort      (abort),
        .trig       (trig),
        .ffa_n      (ffa_n),
        .fifo_dout  (fifo_dout),
        .load       (load),
        .rden       (rden),
        .cntrl_bits (cntrl_bits),
        .out_data   (out_data),
        .out_ch     (out_ch),
        .out_last   (out_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] store_word(input int ch, input int addr);
        return DATA_W'(ch * 4951 + addr * 257 + 5);
    endfunction

    // Store model: fills until WORDS loads, read address resets on select change
    assign ffa_n     = (load_cnt < WORDS);
    assign fifo_dout = pipe[READ_LAT-1];

    always @(posedge clk) begin
        if (store_clr) load_cnt <= 0;
        else if (load) load_cnt <= load_cnt + 1;
        if (rst || (cntrl_bits != sel_q)) begin
            sel_q   <= cntrl_bits;
            rd_addr <= 0;
        end else if (rden) begin
            rd_addr <= rd_addr + 1;
        end
        pipe[0] <= rden ? store_word(int'(cntrl_bits), rd_addr) : 16'hDEAD;
        for (int k = 1; k < READ_LAT; k++) pipe[k] <= pipe[k-1];
    end

    // Stream scoreboard and event counters, sampled mid-cycle
    always @(negedge clk) begin
        if (rden) rden_cnt++;
        if (done) done_cnt++;
        if (out_valid && out_ready) begin
            pop_cnt++;
            if (out_last) last_cnt++;
            checks++;
            got = {out_last, out_ch, out_data};
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL stream_extra: got %h, expected no word", got);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    errors++;
                    $display("[TB] FAIL stream_word: got last/ch/data %h, expected %h", got, want);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run();
        exp_q.delete();
        store_clr = 1'b1;
        tick();
        store_clr = 1'b0;
        for (int c = 0; c < NUM_CH; c++)
            for (int w = 0; w < WORDS; w++)
                exp_q.push_back({(c == NUM_CH - 1) && (w == WORDS - 1), 3'(c), store_word(c, w)});
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < LIMIT; i++) begin
            tick();
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (2) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        checks++;
        if ({load, rden, cntrl_bits, out_valid, out_last, busy, done} !== 9'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %b, expected all zero",
                     {load, rden, cntrl_bits, out_valid, out_last, busy, done});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_nominal();
        int d0, l0;
        bit ok;
        d0 = done_cnt;
        l0 = last_cnt;
        out_ready = 1'b1;
        start_run();
        repeat (9) tick();
        trig = 1'b1;
        tick();
        trig = 1'b0;
        wait_idle(ok);
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL nominal_timeout: busy still %b, expected 0", busy); end
        checks++;
        if (load_cnt != WORDS) begin errors++; $display("[TB] FAIL nominal_loads: got %0d, expected %0d", load_cnt, WORDS); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL nominal_words_missing: got %0d left, expected 0", exp_q.size()); end
        checks++;
        if (done_cnt - d0 != 1) begin errors++; $display("[TB] FAIL nominal_done: got %0d pulses, expected 1", done_cnt - d0); end
        checks++;
        if (last_cnt - l0 != 1) begin errors++; $display("[TB] FAIL nominal_last: got %0d, expected 1", last_cnt - l0); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL nominal_busy_end: got %b, expected 0", busy); end
    endtask

    task automatic test_backpressure();
        int r0, d0, l0, p0, sr;
        bit stretched;
        stretched = 1'b0;
        d0 = done_cnt;
        l0 = last_cnt;
        p0 = pop_cnt;
        r0 = rden_cnt;
        out_ready = 1'b0;
        start_run();
        trig = 1'b1;
        tick();
        trig = 1'b0;
        repeat (60) tick();
        checks++;
        if (rden_cnt - r0 != READ_LAT + 2) begin
            errors++;
            $display("[TB] FAIL bp_issue_limit: got %0d rden, expected %0d", rden_cnt - r0, READ_LAT + 2);
        end
        checks++;
        if (out_valid !== 1'b1 || {out_last, out_ch, out_data} !== exp_q[0]) begin
            errors++;
            $display("[TB] FAIL bp_head_hold: got valid %b word %h, expected valid 1 word %h",
                     out_valid, {out_last, out_ch, out_data}, exp_q[0]);
        end
        for (int i = 0; i < 4 * LIMIT && busy; i++) begin
            if (!stretched && (pop_cnt - p0 >= 3 * WORDS + WORDS / 2)) begin
                out_ready = 1'b0;
                sr = rden_cnt;
                repeat (100) tick();
                checks++;
                if (rden_cnt - sr > READ_LAT + 2) begin
                    errors++;
                    $display("[TB] FAIL bp_stretch_issue: got %0d rden, expected at most %0d", rden_cnt - sr, READ_LAT + 2);
                end
                sr = rden_cnt;
                repeat (100) tick();
                checks++;
                if (rden_cnt != sr) begin
                    errors++;
                    $display("[TB] FAIL bp_stretch_stall: got %0d rden, expected 0", rden_cnt - sr);
                end
                stretched = 1'b1;
            end
            out_ready = (i % 3 == 0);
            tick();
        end
        out_ready = 1'b1;
        repeat (2) tick();
        checks++;
        if (busy !== 1'b0 || !stretched) begin
            errors++;
            $display("[TB] FAIL bp_timeout: got busy %b stretched %b, expected 0 and 1", busy, stretched);
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL bp_words_missing: got %0d left, expected 0", exp_q.size()); end
        checks++;
        if (done_cnt - d0 != 1 || last_cnt - l0 != 1) begin
            errors++;
            $display("[TB] FAIL bp_done_last: got done %0d last %0d, expected 1 and 1", done_cnt - d0, last_cnt - l0);
        end
    endtask

    task automatic test_settle();
        logic [2:0]          prev_sel;
        logic [READ_LAT-1:0] hist;
        int                  last_change, changes;
        bit                  waiting;
        prev_sel    = cntrl_bits;
        hist        = '0;
        last_change = 0;
        changes     = 0;
        waiting     = 1'b0;
        out_ready   = 1'b1;
        start_run();
        trig = 1'b1;
        tick();
        trig = 1'b0;
        for (int i = 0; i < LIMIT; i++) begin
            if (cntrl_bits !== prev_sel) begin
                checks++;
                if (hist != '0) begin
                    errors++;
                    $display("[TB] FAIL settle_sel_busy: reads in flight %b at select change, expected none", hist);
                end
                prev_sel    = cntrl_bits;
                last_change = i;
                waiting     = 1'b1;
                changes++;
            end
            if (waiting && rden) begin
                checks++;
                if (i - last_change < SETTLE + 1) begin
                    errors++;
                    $display("[TB] FAIL settle_gap: got %0d cycles, expected at least %0d", i - last_change, SETTLE + 1);
                end
                waiting = 1'b0;
            end
            hist = READ_LAT'({hist, rden});
            if (!busy) break;
            tick();
        end
        repeat (2) tick();
        checks++;
        if (changes != NUM_CH || exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL settle_run: got %0d changes %0d left, expected %0d changes 0 left", changes, exp_q.size(), NUM_CH);
        end
    endtask

    task automatic test_abort();
        int  d0, n5;
        bit  hit, ok;
        d0  = done_cnt;
        n5  = 0;
        hit = 1'b0;
        out_ready = 1'b1;
        start_run();
        trig = 1'b1;
        tick();
        trig = 1'b0;
        for (int i = 0; i < LIMIT && !hit; i++) begin
            if (rden && cntrl_bits == 3'd5) begin
                if (n5 == 10) begin
                    abort = 1'b1;
                    hit   = 1'b1;
                end else begin
                    n5++;
                end
            end
            tick();
        end
        abort = 1'b0;
        checks++;
        if (!hit || {busy, rden, out_valid, load} !== 4'b0) begin
            errors++;
            $display("[TB] FAIL abort_state: got hit %b busy/rden/valid/load %b, expected 1 and 0000",
                     hit, {busy, rden, out_valid, load});
        end
        exp_q.delete();
        repeat (5) tick();
        checks++;
        if (done_cnt != d0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_no_done: got %0d done busy %b, expected 0 done busy 0", done_cnt - d0, busy);
        end
        d0 = done_cnt;
        start_run();
        trig = 1'b1;
        tick();
        trig = 1'b0;
        wait_idle(ok);
        checks++;
        if (!ok || exp_q.size() != 0 || done_cnt - d0 != 1) begin
            errors++;
            $display("[TB] FAIL abort_rerun: got ok %b left %0d done %0d, expected 1 0 1", ok, exp_q.size(), done_cnt - d0);
        end
    endtask

    task automatic test_reset_capture();
        start_run();
        exp_q.delete();
        trig = 1'b1;
        tick();
        trig = 1'b0;
        repeat (3) tick();
        checks++;
        if (load !== 1'b1) begin errors++; $display("[TB] FAIL rst_cap_load: got %b, expected 1", load); end
        rst = 1'b1;
        tick();
        checks++;
        if ({load, rden, cntrl_bits, out_valid, out_last, busy, done} !== 9'b0) begin
            errors++;
            $display("[TB] FAIL rst_cap_outputs: got %b, expected all zero",
                     {load, rden, cntrl_bits, out_valid, out_last, busy, done});
        end
        rst   = 1'b0;
        arm   = 1'b1;
        abort = 1'b1;
        tick();
        arm   = 1'b0;
        abort = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || load !== 1'b0) begin
            errors++;
            $display("[TB] FAIL arm_abort_same: got busy %b load %b, expected 0 0", busy, load);
        end
    endtask

    task automatic test_trigger_gating();
        bit seen;
        seen = 1'b0;
        trig = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (load || busy) seen = 1'b1;
        end
        checks++;
        if (seen) begin errors++; $display("[TB] FAIL trig_idle: got load/busy 1, expected 0"); end
        start_run();
        exp_q.delete();
        checks++;
        if (load !== 1'b0) begin errors++; $display("[TB] FAIL trig_armed_load: got %b, expected 0", load); end
        tick();
        checks++;
        if (load !== 1'b1) begin errors++; $display("[TB] FAIL trig_load_delay: got %b, expected 1", load); end
        trig  = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || load !== 1'b0) begin
            errors++;
            $display("[TB] FAIL trig_abort: got busy %b load %b, expected 0 0", busy, load);
        end
    endtask

    initial begin
        rst       = 1'b1;
        arm       = 1'b0;
        abort     = 1'b0;
        trig      = 1'b0;
        out_ready = 1'b0;
        store_clr = 1'b0;
        for (int k = 0; k < READ_LAT; k++) pipe[k] = '0;
        test_reset();
        test_nominal();
        test_backpressure();
        test_settle();
        test_abort();
        test_reset_capture();
        test_trigger_gating();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
